inst_fetch: RTL and testbench

- Instruction-fetch stage directly downstream of program_counter.
- Takes the current 8-bit PC value and issues a request/acknowledge read to instruction memory.
- Holds the returned word in an output register with a valid/ready handshake toward decode.
- Pulses pc_en to advance the PC once per accepted fetch, and discards in-flight or buffered instructions on flush (taken branch).

---
 rtl/inst_fetch.sv | 150 +++++++++++++++
 tb/tb_inst_fetch.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: PC -> imem req/ack -> buffered instr toward decode.
// Optional IF_STATS_EN adds saturating fetch_cnt/stall_cnt outputs.
module inst_fetch #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_value,
  output logic              pc_en,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready
`ifdef IF_STATS_EN
  ,
  output logic [15:0]       fetch_cnt,
  output logic [15:0]       stall_cnt
`endif
);

  typedef enum logic [1:0] {
    START,
    FETCH,
    FULL,
    DRAIN
  } state_e;

  state_e state_q, state_d;

  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic              valid_q, valid_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= START;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      START: state_d = FETCH;
      FETCH: begin
        if (imem_ack && !flush) state_d = FULL;
        else if (!imem_ack && flush) state_d = DRAIN;
      end
      FULL: begin
        if (flush || instr_ready) state_d = FETCH;
      end
      DRAIN: begin
        if (imem_ack) state_d = FETCH;
      end
      default: state_d = START;
    endcase
  end

  always_comb begin
    req_d   = req_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    unique case (state_q)
      START: begin
        req_d  = 1'b1;
        addr_d = pc_value;
      end
      FETCH: begin
        if (imem_ack && !flush) begin
          instr_d = imem_rdata;
          ipc_d   = addr_q;
          valid_d = 1'b1;
          req_d   = 1'b0;
        end else if (imem_ack) begin
          addr_d = pc_value;
        end
      end
      FULL: begin
        if (flush || instr_ready) begin
          valid_d = 1'b0;
          req_d   = 1'b1;
          addr_d  = pc_value;
        end
      end
      DRAIN: begin
        if (imem_ack) addr_d = pc_value;
      end
      default: begin
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q   <= 1'b0;
      addr_q  <= '0;
      instr_q <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      req_q   <= req_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
    end
  end

  // PC steps on the same edge the fetched word is captured
  assign pc_en = (state_q == FETCH) && imem_ack
               && !flush && !rst;

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = valid_q;

`ifdef IF_STATS_EN
  logic [15:0] fcnt_q, scnt_q;
  logic        stall;

  assign stall = ((state_q == FETCH) || (state_q == DRAIN))
               && !imem_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_q <= '0;
      scnt_q <= '0;
    end else begin
      if (pc_en && fcnt_q != 16'hFFFF) fcnt_q <= fcnt_q + 16'd1;
      if (stall && scnt_q != 16'hFFFF) scnt_q <= scnt_q + 16'd1;
    end
  end

  assign fetch_cnt = fcnt_q;
  assign stall_cnt = scnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: vector table, delayed-ack sequence, random run.
// Build with +define+IF_STATS_EN to also check the stats counters.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst, flush, imem_ack, instr_ready;
  logic [7:0]  pc_value;
  logic        pc_en, imem_req, instr_valid;
  logic [7:0]  imem_addr, instr_pc;
  logic [31:0] imem_rdata, instr;
`ifdef IF_STATS_EN
  logic [15:0] fetch_cnt, stall_cnt;
`endif

  always #5 clk = ~clk;

  assign imem_rdata = 32'h1000_0000 + {24'b0, imem_addr};

  inst_fetch #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .pc_value(pc_value),
    .pc_en(pc_en),
    .flush(flush),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .instr(instr),
    .instr_pc(instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready)
`ifdef IF_STATS_EN
    ,
    .fetch_cnt(fetch_cnt),
    .stall_cnt(stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic       rst;
    logic       flush;
    logic       ack;
    logic       ready;
    logic [7:0] pc;
    logic       pc_en;
    logic       req;
    logic [7:0] addr;
    logic       valid;
    logic [7:0] ipc;
  } vec_t;

  vec_t tv [22];

  logic [7:0] pc_reg, exp_next, tgt, prev_addr, pv;
  logic       prev_req, prev_ack, was_flush, was_en, exp_en;
  bit         stale;
  int         wcnt, lat, nfetch, nstall, idle;

  initial begin
    // rst flush ack ready pc | pc_en req addr valid ipc
    tv[0]  = '{1,0,0,0,8'h00, 0,0,8'h00,0,8'h00};
    tv[1]  = '{0,0,0,1,8'h00, 0,1,8'h00,0,8'h00};
    tv[2]  = '{0,0,1,1,8'h00, 1,0,8'h00,1,8'h00};
    tv[3]  = '{0,0,0,1,8'h01, 0,1,8'h01,0,8'h00};
    tv[4]  = '{0,0,1,1,8'h01, 1,0,8'h01,1,8'h01};
    tv[5]  = '{0,0,0,0,8'h02, 0,0,8'h01,1,8'h01};
    tv[6]  = '{0,0,1,0,8'h02, 0,0,8'h01,1,8'h01};
    tv[7]  = '{0,0,0,1,8'h02, 0,1,8'h02,0,8'h01};
    tv[8]  = '{0,0,0,1,8'h02, 0,1,8'h02,0,8'h01};
    tv[9]  = '{0,1,1,1,8'h40, 0,1,8'h40,0,8'h01};
    tv[10] = '{0,1,0,1,8'h50, 0,1,8'h40,0,8'h01};
    tv[11] = '{0,1,0,1,8'h60, 0,1,8'h40,0,8'h01};
    tv[12] = '{0,0,1,1,8'h60, 0,1,8'h60,0,8'h01};
    tv[13] = '{0,0,1,0,8'h60, 1,0,8'h60,1,8'h60};
    tv[14] = '{0,1,0,0,8'h20, 0,1,8'h20,0,8'h60};
    tv[15] = '{0,0,1,0,8'h20, 1,0,8'h20,1,8'h20};
    tv[16] = '{1,0,0,0,8'h00, 0,0,8'h00,0,8'h00};
    tv[17] = '{0,0,0,0,8'h03, 0,1,8'h03,0,8'h00};
    tv[18] = '{1,0,1,0,8'h03, 0,0,8'h00,0,8'h00};
    tv[19] = '{0,0,0,0,8'hFF, 0,1,8'hFF,0,8'h00};
    tv[20] = '{0,0,1,0,8'hFF, 1,0,8'hFF,1,8'hFF};
    tv[21] = '{0,0,0,1,8'h00, 0,1,8'h00,0,8'hFF};

    rst = 1; flush = 0; imem_ack = 0;
    instr_ready = 0; pc_value = 0;

    for (int i = 0; i < 22; i++) begin
      rst         = tv[i].rst;
      flush       = tv[i].flush;
      imem_ack    = tv[i].ack;
      instr_ready = tv[i].ready;
      pc_value    = tv[i].pc;
      #1;
      chk($sformatf("v%0d pc_en", i), 32'(pc_en), 32'(tv[i].pc_en));
      @(posedge clk); #1;
      chk($sformatf("v%0d req", i), 32'(imem_req), 32'(tv[i].req));
      chk($sformatf("v%0d addr", i), 32'(imem_addr), 32'(tv[i].addr));
      chk($sformatf("v%0d valid", i), 32'(instr_valid),
          32'(tv[i].valid));
      chk($sformatf("v%0d ipc", i), 32'(instr_pc), 32'(tv[i].ipc));
      if (tv[i].valid)
        chk($sformatf("v%0d instr", i), instr,
            32'h1000_0000 + 32'(tv[i].ipc));
    end

    // delayed ack: three wait cycles at address 0x05
    rst = 1; flush = 0; imem_ack = 0; instr_ready = 1; pc_value = 8'h05;
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      imem_ack = (k == 3);
      #1;
      chk("dly pc_en", 32'(pc_en), 32'(k == 3));
      chk("dly req", 32'(imem_req), 32'd1);
      chk("dly addr", 32'(imem_addr), 32'h05);
      @(posedge clk); #1;
    end
    imem_ack = 0; pc_value = 8'h06;
    chk("dly valid", 32'(instr_valid), 32'd1);
    chk("dly ipc", 32'(instr_pc), 32'h05);
    chk("dly instr", instr, 32'h1000_0005);
    chk("dly req off", 32'(imem_req), 32'd0);
`ifdef IF_STATS_EN
    chk("dly fetch_cnt", 32'(fetch_cnt), 32'd1);
    chk("dly stall_cnt", 32'(stall_cnt), 32'd3);
`endif

    // random run against a PC/memory/stream model
    rst = 1; flush = 0; imem_ack = 0; pc_value = 0;
    @(posedge clk); #1;
    rst = 0;
    pc_reg = 0; exp_next = 0; wcnt = 0; lat = $urandom % 4;
    stale = 0; nfetch = 0; nstall = 0; idle = 0;
    for (int c = 0; c < 3000; c++) begin
      prev_req  = imem_req;
      prev_addr = imem_addr;
      flush = ($urandom % 12 == 0);
      tgt   = 8'($urandom);
      pc_value = flush ? tgt : pc_reg;
      if (imem_req) imem_ack = (wcnt >= lat);
      else          imem_ack = ($urandom % 4 == 0);
      instr_ready = ($urandom % 4 != 0);
      #1;
      exp_en = imem_req && imem_ack && !flush && !stale;
      chk("rnd pc_en", 32'(pc_en), 32'(exp_en));
      if (imem_req && !imem_ack) nstall++;
      if (exp_en) nfetch++;
      if (imem_req) begin
        if (imem_ack) begin
          stale = 0; wcnt = 0; lat = $urandom % 4;
        end else begin
          if (flush) stale = 1;
          wcnt++;
        end
      end
      if (flush) begin
        pc_reg = tgt; exp_next = tgt;
      end else if (exp_en) begin
        pc_reg = pc_reg + 8'd1;
      end
      was_flush = flush; was_en = exp_en;
      pv = pc_value; prev_ack = imem_ack;
      @(posedge clk); #1;
      if (was_en) begin
        chk("rnd valid", 32'(instr_valid), 32'd1);
        chk("rnd ipc", 32'(instr_pc), 32'(exp_next));
        chk("rnd instr", instr, 32'h1000_0000 + 32'(exp_next));
        exp_next = exp_next + 8'd1;
        idle = 0;
      end else begin
        idle++;
      end
      if (was_flush) chk("rnd flush valid", 32'(instr_valid), 32'd0);
      if (prev_req && !prev_ack) begin
        chk("rnd req held", 32'(imem_req), 32'd1);
        chk("rnd addr held", 32'(imem_addr), 32'(prev_addr));
      end
      if (imem_req && (!prev_req || prev_ack))
        chk("rnd new addr", 32'(imem_addr), 32'(pv));
      if (idle > 60) begin
        checks++; errors++;
        $display("FAIL rnd liveness: got %0d idle cycles required <= 60",
                 idle);
        idle = 0;
      end
    end
`ifdef IF_STATS_EN
    chk("rnd fetch_cnt", 32'(fetch_cnt), 32'(nfetch));
    chk("rnd stall_cnt", 32'(stall_cnt), 32'(nstall));
`endif

    // reset while holding a valid instruction
    flush = 0; instr_ready = 0; imem_ack = 1; pc_value = 8'h33;
    for (int k = 0; k < 20 && !instr_valid; k++) begin
      @(posedge clk); #1;
    end
    chk("rst pre valid", 32'(instr_valid), 32'd1);
    rst = 1; imem_ack = 0; pc_value = 8'h00;
    #1;
    chk("rst pc_en", 32'(pc_en), 32'd0);
    @(posedge clk); #1;
    chk("rst valid", 32'(instr_valid), 32'd0);
    chk("rst req", 32'(imem_req), 32'd0);
`ifdef IF_STATS_EN
    chk("rst fetch_cnt", 32'(fetch_cnt), 32'd0);
    chk("rst stall_cnt", 32'(stall_cnt), 32'd0);
`endif
    rst = 0;
    @(posedge clk); #1;
    chk("rst restart req", 32'(imem_req), 32'd1);
    chk("rst restart addr", 32'(imem_addr), 32'h00);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
